// File: rtl/mario_pkg.sv
// Shared types and HID key codes for the player motion controller.
package mario_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

endpackage

// File: rtl/key_slot_match.sv
// Reports whether an 8-bit HID usage code appears in any of the four keycode slots.
module key_slot_match (
  input  logic [31:0] keycode,
  input  logic [7:0]  code,
  output logic        hit
);

  assign hit = (keycode[31:24] == code) | (keycode[23:16] == code) |
               (keycode[15:8]  == code) | (keycode[7:0]   == code);

endmodule

// File: rtl/mario_motion_controller.sv
// Frame-locked jump/fall sequencer producing signed per-frame X/Y step velocities.
module mario_motion_controller
  import mario_pkg::*;
#(
  parameter int VEL_W      = 8,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 8,
  parameter int CUT_V      = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_tick,
  input  logic [31:0]             keycode,
  input  logic                    on_ground,
  output logic signed [VEL_W-1:0] x_vel,
  output logic signed [VEL_W-1:0] y_vel,
  output logic                    facing_left,
  output logic                    walking,
  output logic [1:0]              jump_state
);

  localparam int W1 = VEL_W + 1;
  localparam logic signed [W1-1:0] GRAV_E   = W1'(GRAVITY);
  localparam logic signed [W1-1:0] MAX_E    = W1'(MAX_FALL);
  localparam logic signed [W1-1:0] NEG_CUT  = W1'(-CUT_V);
  localparam logic signed [VEL_W-1:0] NEG_JUMP = VEL_W'(-JUMP_V);
  localparam logic signed [VEL_W-1:0] POS_WALK = VEL_W'(WALK_SPEED);
  localparam logic signed [VEL_W-1:0] NEG_WALK = VEL_W'(-WALK_SPEED);
  localparam logic signed [VEL_W-1:0] GRAV_V   = VEL_W'(GRAVITY);

  logic w_hit, a_hit, d_hit;

  key_slot_match u_match_w (.keycode(keycode), .code(KEY_W), .hit(w_hit));
  key_slot_match u_match_a (.keycode(keycode), .code(KEY_A), .hit(a_hit));
  key_slot_match u_match_d (.keycode(keycode), .code(KEY_D), .hit(d_hit));

  jump_state_t state;
  logic        w_prev;
  logic        w_rise;

  logic signed [VEL_W-1:0] x_next;
  logic signed [W1-1:0]    y_ext;
  logic signed [W1-1:0]    t_add;
  logic signed [W1-1:0]    rise_t;
  logic signed [W1-1:0]    fall_t;

  // One extra bit of headroom so y_vel + GRAVITY never wraps before the compares.
  always_comb begin
    x_next = '0;
    if (a_hit && !d_hit)      x_next = NEG_WALK;
    else if (d_hit && !a_hit) x_next = POS_WALK;

    w_rise = w_hit & ~w_prev;
    y_ext  = {y_vel[VEL_W-1], y_vel};
    t_add  = y_ext + GRAV_E;

    rise_t = t_add;
    if (!w_hit && (t_add < NEG_CUT)) rise_t = NEG_CUT;

    fall_t = (t_add > MAX_E) ? MAX_E : t_add;
  end

  // frame_tick qualifies every update; inputs are ignored in all other cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_vel       <= '0;
      y_vel       <= '0;
      facing_left <= 1'b0;
      walking     <= 1'b0;
      state       <= GROUND;
      w_prev      <= 1'b0;
    end else if (frame_tick) begin
      x_vel   <= x_next;
      walking <= (x_next != '0);
      if (a_hit && !d_hit)      facing_left <= 1'b1;
      else if (d_hit && !a_hit) facing_left <= 1'b0;
      w_prev <= w_hit;

      case (state)
        RISE: begin
          y_vel <= rise_t[VEL_W-1:0];
          if (rise_t >= 0) state <= FALL;
        end
        FALL: begin
          // Landing beats a same-tick W press: no jump on the landing frame.
          if (on_ground) begin
            state <= GROUND;
            y_vel <= '0;
          end else begin
            y_vel <= fall_t[VEL_W-1:0];
          end
        end
        default: begin
          // GROUND, and the unused encoding recovers through the same path.
          if (w_rise && on_ground) begin
            state <= RISE;
            y_vel <= NEG_JUMP;
          end else if (!on_ground) begin
            state <= FALL;
            y_vel <= GRAV_V;
          end else begin
            state <= GROUND;
            y_vel <= '0;
          end
        end
      endcase
    end
  end

  assign jump_state = state;

endmodule

// File: tb/tb_mario_motion_controller.sv
// Directed table-driven bench for the player motion controller.
module tb_mario_motion_controller;

  logic              Clk;
  logic              Reset;
  logic              frame_tick;
  logic [31:0]       keycode;
  logic              on_ground;
  logic signed [7:0] x_vel;
  logic signed [7:0] y_vel;
  logic              facing_left;
  logic              walking;
  logic [1:0]        jump_state;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] S_G = 2'd0;
  localparam logic [1:0] S_R = 2'd1;
  localparam logic [1:0] S_F = 2'd2;

  typedef struct {
    logic [31:0] key;
    logic        og;
    int          ex;
    int          ey;
    logic        ef;
    logic        ew;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs[$];

  mario_motion_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .on_ground  (on_ground),
    .x_vel      (x_vel),
    .y_vel      (y_vel),
    .facing_left(facing_left),
    .walking    (walking),
    .jump_state (jump_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey,
                           input logic ef, input logic ew, input logic [1:0] es);
    check({tag, ".x_vel"},  int'(x_vel), ex);
    check({tag, ".y_vel"},  int'(y_vel), ey);
    check({tag, ".facing"}, int'(facing_left), int'(ef));
    check({tag, ".walking"}, int'(walking), int'(ew));
    check({tag, ".state"},  int'(jump_state), int'(es));
  endtask

  // driver: one frame tick with the given inputs, outputs sampled on the next negedge
  task automatic do_tick(input logic [31:0] k, input logic og);
    @(negedge Clk);
    keycode    = k;
    on_ground  = og;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  function automatic void add(input logic [31:0] k, input logic og, input int ex,
                              input int ey, input logic ef, input logic ew,
                              input logic [1:0] es);
    vec_t v;
    v.key = k; v.og = og; v.ex = ex; v.ey = ey; v.ef = ef; v.ew = ew; v.es = es;
    vecs.push_back(v);
  endfunction

  initial begin
    Reset      = 1'b0;
    frame_tick = 1'b0;
    keycode    = '0;
    on_ground  = 1'b1;

    // walking and key decode
    add(32'h0000_0004, 1, -2, 0, 1, 1, S_G);
    add(32'h0000_0704, 1,  0, 0, 1, 0, S_G);
    add(32'h0700_0707, 1,  2, 0, 0, 1, S_G);
    add(32'h0000_0000, 1,  0, 0, 0, 0, S_G);
    // full jump with W held, on_ground ignored while rising
    add(32'h1A00_0000, 1, 0, -12, 0, 0, S_R);
    for (int i = 11; i >= 1; i--) add(32'h1A00_0000, 1, 0, -i, 0, 0, S_R);
    add(32'h1A00_0000, 0, 0, 0, 0, 0, S_F);
    for (int i = 1; i <= 8; i++) add(32'h0000_1A07, 0, 2, i, 0, 1, S_F);
    add(32'h0000_1A07, 0, 2, 8, 0, 1, S_F);
    add(32'h1A00_0000, 1, 0, 0, 0, 0, S_G);
    add(32'h1A00_0000, 1, 0, 0, 0, 0, S_G);
    add(32'h0000_0000, 1, 0, 0, 0, 0, S_G);
    // short hop: W released after two ticks
    add(32'h0000_001A, 1, 0, -12, 0, 0, S_R);
    add(32'h0000_001A, 1, 0, -11, 0, 0, S_R);
    add(32'h0000_0000, 1, 0, -4, 0, 0, S_R);
    add(32'h0000_0000, 1, 0, -3, 0, 0, S_R);
    add(32'h0000_0000, 1, 0, -2, 0, 0, S_R);
    add(32'h0000_0000, 1, 0, -1, 0, 0, S_R);
    add(32'h0000_0000, 1, 0, 0, 0, 0, S_F);
    add(32'h0000_0000, 1, 0, 0, 0, 0, S_G);
    // walk off a ledge, land with a fresh W press, then need another press
    add(32'h0000_0000, 0, 0, 1, 0, 0, S_F);
    add(32'h001A_0000, 1, 0, 0, 0, 0, S_G);
    add(32'h001A_0000, 1, 0, 0, 0, 0, S_G);
    add(32'h0000_0000, 1, 0, 0, 0, 0, S_G);
    add(32'h001A_0000, 1, 0, -12, 0, 0, S_R);

    // reset pulsed together with a tick and a W press
    @(negedge Clk);
    Reset      = 1'b1;
    frame_tick = 1'b1;
    keycode    = 32'h0000_001A;
    @(negedge Clk);
    @(negedge Clk);
    Reset      = 1'b0;
    frame_tick = 1'b0;
    keycode    = '0;
    check_all("reset", 0, 0, 1'b0, 1'b0, S_G);

    for (int i = 0; i < vecs.size(); i++) begin
      do_tick(vecs[i].key, vecs[i].og);
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ef,
                vecs[i].ew, vecs[i].es);
    end

    // inputs toggled without a tick must not move anything (currently RISE, -12)
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      keycode   = (i % 2 == 0) ? 32'h0000_0004 : 32'h0700_0000;
      on_ground = i[0];
    end
    @(negedge Clk);
    check_all("no_tick", 0, -12, 1'b0, 1'b0, S_R);

    // one more tick with W still held keeps rising
    do_tick(32'h001A_0000, 1);
    check_all("rise2", 0, -11, 1'b0, 1'b0, S_R);

    // reset mid-rise, no tick
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_all("reset_mid", 0, 0, 1'b0, 1'b0, S_G);

    // after reset w_prev is clear, so a held W jumps again
    do_tick(32'h001A_0000, 1);
    check_all("post_reset_jump", 0, -12, 1'b0, 1'b0, S_R);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
